// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and defaults for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_DEPTH = 256;
    localparam int WORD_LSB = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage with synchronous write and registered read
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store target with req/ready handshake and one-cycle ack
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);
    localparam int IW = ADDR_W - WORD_LSB;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic we_q, rd_ok, accept, access, cur_we, bad;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic [31:0] wdata_q, cur_wdata, arr_q;
    logic [IW-1:0] idx;
    // with zero latency the access happens on the accept edge, so use live inputs there
    assign accept = req_i && state == IDLE;
    assign access = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd0);
    assign cur_we = (state == IDLE) ? we_i : we_q;
    assign cur_addr = (state == IDLE) ? addr_i : addr_q;
    assign cur_wdata = (state == IDLE) ? wdata_i : wdata_q;
    assign idx = cur_addr[ADDR_W-1:WORD_LSB];
    assign bad = cur_addr[WORD_LSB-1:0] != '0 || idx >= IW'(DEPTH);
    assign rdata_o = rd_ok ? arr_q : '0;
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk(clk_i),
        .we(access && cur_we && !bad),
        .re(access && !cur_we && !bad),
        .addr(idx[AW-1:0]),
        .wdata(cur_wdata),
        .rdata(arr_q)
    );
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (req_i ? ((LATENCY == 0) ? RESP : WAIT) : IDLE)
                  : (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT)
                  : IDLE;
    end
    always_comb begin
        ready_o = state == IDLE;
        ack_o = state == RESP;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            err_o <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= CNT_INIT;
                we_q <= we_i;
                addr_q <= addr_i;
                wdata_q <= wdata_i;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_o <= bad;
                rd_ok <= !cur_we && !bad;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized checks of two responders (LATENCY 2 and 0) against a word-array model
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req [2];
    logic we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic ready [2];
    logic ack [2];
    logic [31:0] rdata [2];
    logic err [2];
    logic [31:0] model [2][256];
    bit written [2][256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );
    dmem_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    // One full transaction on instance k, checking every cycle from accept to return-to-idle.
    task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input bit churn);
        int lat;
        int n;
        logic bad;
        logic [31:0] exp_r;
        lat = (k == 0) ? 2 : 0;
        bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        exp_r = (!w && !bad) ? model[k][a[9:2]] : 32'h0;
        n = 0;
        while (!ready[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait k=%0d got=%b want=1", k, ready[k]);
        end
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        if (!churn) req[k] = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            if (churn) begin
                addr[k] = $urandom; wdata[k] = $urandom; we[k] = 1'($urandom);
            end
            checks++;
            if (ack[k] !== (c == lat + 1) || ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL ack_timing k=%0d cyc=%0d ack=%b ready=%b want ack=%b ready=0", k, c, ack[k], ready[k], c == lat + 1);
            end
            if (c < lat + 1) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (err[k] !== bad || rdata[k] !== exp_r) begin
            errors++;
            $display("FAIL resp k=%0d we=%b addr=%h err=%b rdata=%h want err=%b rdata=%h", k, w, a, err[k], rdata[k], bad, exp_r);
        end
        if (w && !bad) begin
            model[k][a[9:2]] = d;
            written[k][a[9:2]] = 1'b1;
        end
        @(posedge clk); #1;
        req[k] = 1'b0;
        checks++;
        if (ack[k] !== 1'b0 || ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL post_ack k=%0d ack=%b ready=%b want ack=0 ready=1", k, ack[k], ready[k]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready[k] !== 1'b1 || ack[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state k=%0d ready=%b ack=%b rdata=%h err=%b want 1 0 0 0", k, ready[k], ack[k], rdata[k], err[k]);
            end
        end
    endtask

    task automatic test_store_load();
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_lat0();
        xact(1, 1'b1, 32'h0, 32'h12345678, 1'b0);
        xact(1, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_errors();
        xact(0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 1'b0);
        xact(0, 1'b0, 32'h400, 32'h0, 1'b0);
        xact(1, 1'b0, 32'h400, 32'h0, 1'b0);
        xact(1, 1'b1, 32'h2, 32'h0BAD0BAD, 1'b0);
        xact(1, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_churn();
        xact(0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1);
        xact(0, 1'b0, 32'h20, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        xact(0, 1'b1, 32'h30, 32'h0, 1'b0);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack[0] !== 1'b0 || ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_wait ack=%b ready=%b want ack=0 ready=1", ack[0], ready[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ack[0] !== 1'b0 || ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL after_reset cyc=%0d ack=%b ready=%b want ack=0 ready=1", c, ack[0], ready[0]);
            end
            @(posedge clk); #1;
        end
        xact(0, 1'b0, 32'h30, 32'h0, 1'b0);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; wdata[1] = 32'h0;
        @(posedge clk); #1;
        req[1] = 1'b0;
        checks++;
        if (ack[1] !== 1'b1) begin
            errors++;
            $display("FAIL resp_before_reset ack=%b want 1", ack[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack[1] !== 1'b0 || ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_resp ack=%b ready=%b want ack=0 ready=1", ack[1], ready[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int k;
        logic w;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 1));
            w = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
                1: a = 32'h400 + 32'({$urandom_range(0, 1000), 2'b00});
                default: a = 32'({$urandom_range(0, 15), 2'b00});
            endcase
            if (!w && a[1:0] == 2'b00 && a < 32'h400 && !written[k][a[9:2]]) w = 1'b1;
            xact(k, w, a, $urandom, 1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        test_reset();
        test_store_load();
        test_lat0();
        test_errors();
        test_churn();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target side of the CPU's load/store request interface.
- Accepts one request at a time through a req/ready handshake and waits a fixed number of cycles.
- Then performs the read or write and returns a one-cycle ack carrying read data and an error flag.
- Sits between the MEM stage and backing storage; wait states let the bench exercise stall logic.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of 32-bit words stored.
- LATENCY, 2, wait cycles between the accept edge and the access edge; range 0..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  1  request valid.
- we_i  input  1  1 = store, 0 = load; sampled with req_i.
- addr_i  input  ADDR_W  byte address; sampled with req_i.
- wdata_i  input  32  store data; sampled with req_i.
- ready_o  output  1  responder can accept a request this cycle.
- ack_o  output  1  one-cycle response strobe.
- rdata_o  output  32  load data, valid when ack_o=1.
- err_o  output  1  access error, valid when ack_o=1.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE, wait counter 0, ack_o=0, rdata_o=0, err_o=0. ready_o=1 as soon as reset releases. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP. ready_o=1 only in IDLE (decoded from state).
- Accept: req_i=1 and ready_o=1 at a rising edge. On that edge we_i, addr_i and wdata_i are latched; later changes are ignored until the next accept.
- IDLE, accept, LATENCY=0: perform the access on this same edge, go to RESP.
- IDLE, accept, LATENCY>0: load counter with LATENCY-1, go to WAIT.
- WAIT, counter>0: decrement. req_i is ignored.
- WAIT, counter=0: perform the access on this edge, go to RESP.
- RESP: ack_o=1 for exactly one cycle, then IDLE on the next edge.
- Latency: ack_o is high in the cycle LATENCY+1 cycles after the accept edge.
- Throughput: one request per LATENCY+2 cycles. No back-to-back accept from RESP.
- Word index = latched addr[ADDR_W-1:2].
- Error when addr[1:0]!=0 or word index>=DEPTH. Then err_o=1 with ack, no write occurs, and rdata_o=0.
- Valid load: rdata_o = mem[index], registered on the access edge.
- Valid store: mem[index] = wdata, rdata_o=0, err_o=0.
- rdata_o and err_o hold their values until the next access edge.
- Reset asserted in WAIT: the pending store is dropped (memory unchanged) and no ack is issued.
- Reset asserted in RESP: ack_o drops immediately.
- req_i held high through RESP: not accepted until IDLE. The requester must not assume acceptance before ready_o=1.

Decomposition:
- Shared package (dmem_pkg): state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the default LATENCY and DEPTH, and the word-select slice constant (bit 2 upward).
- One natural sub-module, dmem_array: DEPTH x 32 storage with a synchronous write-enable port and a registered read port. No reset on the array.
- The FSM, latches and error check stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF: ack_o high exactly 3 cycles after the accept edge, err_o=0.
  - Load addr=0x10: rdata_o=0xDEADBEEF with ack.
- LATENCY=0 load of word 0 preloaded with 0x12345678: ack_o in the cycle after accept, rdata_o=0x12345678, ready_o low for exactly 1 cycle.
- Misaligned store addr=0x13, wdata=0xFFFFFFFF: ack with err_o=1, rdata_o=0. A following load of 0x10 still returns the prior value.
- Out-of-range load addr=4*DEPTH (0x400): ack with err_o=1, rdata_o=0.
- Input churn: change addr_i and wdata_i during WAIT after a store to 0x20 of 0xA5A5A5A5. A load of 0x20 returns 0xA5A5A5A5, and no extra accept occurs while req_i stays high.
- Reset mid-operation:
  - Assert rst_i=0 during WAIT of a store to 0x30 (old value 0x0): ack_o never pulses and ready_o=1 after release.
  - A load of 0x30 then returns 0x0.
